// File: rtl/aon_wdog_pkg.sv
// Shared AON watchdog definitions: register map, CTRL fields, FSM states, feed key.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package aon_wdog_pkg;

  // Register word addresses
  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_CMP_IRQ = 3'd1;
  localparam logic [2:0] ADDR_CMP_RST = 3'd2;
  localparam logic [2:0] ADDR_FEED    = 3'd3;
  localparam logic [2:0] ADDR_COUNT   = 3'd4;

  // CTRL bit fields
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_PRESC_LSB = 4;
  localparam int CTRL_PRESC_MSB = 7;

  // Magic value software must write to FEED ("WDOG")
  localparam logic [31:0] FEED_KEY_DEFAULT = 32'h5744_4F47;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_IRQ  = 2'd2,
    ST_RST  = 2'd3
  } wdog_state_t;

endpackage

// File: rtl/aon_wdog_presc.sv
// Watchdog prescaler: 16-bit free counter producing a tick every 2^presc cycles.
// Latency: tick is combinational from the registered counter.
// Backpressure: none; counter is held at 0 whenever run is low or clr is high.
//
// Ports:
//   clk, resetn   AON clock, synchronous active-low reset
//   run           count enable (watchdog in RUN/IRQ)
//   clr           synchronous clear (feed or disable)
//   presc         tick period exponent
//   tick          one-cycle count enable for the watchdog counter
module aon_wdog_presc (
  input  logic       clk,
  input  logic       resetn,
  input  logic       run,
  input  logic       clr,
  input  logic [3:0] presc,
  output logic       tick
);

  logic [15:0] cnt;
  logic [15:0] mask;

  // Low presc bits all ones -> tick; presc=0 gives an empty mask, so every cycle ticks.
  always_comb begin
    mask = (16'd1 << presc) - 16'd1;
  end

  assign tick = run & ((cnt & mask) == mask);

  always_ff @(posedge clk) begin
    if (!resetn || clr || !run) begin
      cnt <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/aon_wdog.sv
// Always-on watchdog: counts prescaled ticks, raises an IRQ then a timed reset request.
// Latency: reg_ready one cycle after reg_valid; state follows threshold compares by one cycle.
// Backpressure: requester holds reg_valid until reg_ready; one access per two cycles at most.
//
// Ports:
//   clk, resetn                 AON clock, synchronous active-low reset
//   reg_valid/write/addr/wdata  register access request
//   reg_ready/rdata             one-cycle completion, read data valid with it
//   wdog_irq                    level interrupt (IRQ and RST states)
//   wdog_rst_req                reset request, high for RST_PULSE cycles
module aon_wdog
  import aon_wdog_pkg::*;
#(
  parameter int          CNT_W     = 32,
  parameter int          RST_PULSE = 16,
  parameter logic [31:0] FEED_KEY  = FEED_KEY_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        reg_valid,
  input  logic        reg_write,
  input  logic [2:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic        reg_ready,
  output logic [31:0] reg_rdata,
  output logic        wdog_irq,
  output logic        wdog_rst_req
);

  localparam int              RC_W     = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam logic [RC_W-1:0] RST_LAST = RC_W'(RST_PULSE - 1);

  wdog_state_t      state;
  logic             en;
  logic [3:0]       presc;
  logic [CNT_W-1:0] cmp_irq;
  logic [CNT_W-1:0] cmp_rst;
  logic [CNT_W-1:0] count;
  logic [RC_W-1:0]  rst_cnt;

  logic wr_fire;
  logic ctrl_wr;
  logic cmpi_wr;
  logic cmpr_wr;
  logic feed_wr;
  logic running;
  logic feed_ok;
  logic dis_ok;
  logic tick;

  // Writes commit on the edge that ends the reg_ready cycle.
  assign wr_fire = reg_valid & reg_ready & reg_write;
  assign ctrl_wr = wr_fire && (reg_addr == ADDR_CTRL);
  assign cmpi_wr = wr_fire && (reg_addr == ADDR_CMP_IRQ);
  assign cmpr_wr = wr_fire && (reg_addr == ADDR_CMP_RST);
  assign feed_wr = wr_fire && (reg_addr == ADDR_FEED);

  assign running = (state == ST_RUN) || (state == ST_IRQ);
  assign feed_ok = feed_wr && (reg_wdata == FEED_KEY) && running;
  assign dis_ok  = ctrl_wr && !reg_wdata[CTRL_EN_BIT] && running;

  aon_wdog_presc u_presc (
    .clk    (clk),
    .resetn (resetn),
    .run    (running),
    .clr    (feed_ok | dis_ok),
    .presc  (presc),
    .tick   (tick)
  );

  // Register port handshake: ready pulses for one cycle per request.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      reg_ready <= 1'b0;
    end else begin
      reg_ready <= reg_valid & ~reg_ready;
    end
  end

  always_comb begin
    reg_rdata = 32'd0;
    if (reg_ready) begin
      case (reg_addr)
        ADDR_CTRL:    reg_rdata = {24'd0, presc, 3'd0, en};
        ADDR_CMP_IRQ: reg_rdata = 32'(cmp_irq);
        ADDR_CMP_RST: reg_rdata = 32'(cmp_rst);
        ADDR_COUNT:   reg_rdata = 32'(count);
        default:      reg_rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      en      <= 1'b0;
      presc   <= 4'd0;
      cmp_irq <= '1;
      cmp_rst <= '1;
      count   <= '0;
      rst_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          count <= '0;
          // Configuration is only writable while stopped.
          if (cmpi_wr) cmp_irq <= reg_wdata[CNT_W-1:0];
          if (cmpr_wr) cmp_rst <= reg_wdata[CNT_W-1:0];
          if (ctrl_wr) begin
            en    <= reg_wdata[CTRL_EN_BIT];
            presc <= reg_wdata[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
            if (reg_wdata[CTRL_EN_BIT]) state <= ST_RUN;
          end
        end
        ST_RUN, ST_IRQ: begin
          // Feed and disable override a threshold hit in the same cycle.
          if (feed_ok) begin
            count <= '0;
            state <= ST_RUN;
          end else if (dis_ok) begin
            count <= '0;
            en    <= 1'b0;
            state <= ST_IDLE;
          end else begin
            if (tick && (count != '1)) count <= count + CNT_W'(1);
            if (count >= cmp_rst) begin
              state <= ST_RST;
            end else if (count >= cmp_irq) begin
              state <= ST_IRQ;
            end
          end
        end
        ST_RST: begin
          if (rst_cnt == RST_LAST) begin
            rst_cnt <= '0;
            count   <= '0;
            en      <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign wdog_irq     = (state == ST_IRQ) || (state == ST_RST);
  assign wdog_rst_req = (state == ST_RST);

endmodule

// File: tb/tb_aon_wdog.sv
// Directed bench for aon_wdog: register reads scored through an expected-value queue.
// Latency: timing checks are expressed in clock edges after a write commit edge.
// Backpressure: every wait on reg_ready is bounded.
module tb_aon_wdog;
  import aon_wdog_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        reg_valid;
  logic        reg_write;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_ready;
  logic [31:0] reg_rdata;
  logic        wdog_irq;
  logic        wdog_rst_req;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base  = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  aon_wdog dut (
    .clk          (clk),
    .resetn       (resetn),
    .reg_valid    (reg_valid),
    .reg_write    (reg_write),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_ready    (reg_ready),
    .reg_rdata    (reg_rdata),
    .wdog_irq     (wdog_irq),
    .wdog_rst_req (wdog_rst_req)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hung expected=finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Edge numbering is relative to the edge that committed the last mark()ed write.
  task automatic mark();
    base = cyc;
  endtask

  task automatic wait_to(input int a);
    while (cyc < base + a) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic peek(input int a);
    wait_to(a);
    @(negedge clk);
  endtask

  task automatic access(input logic wr, input logic [2:0] a, input logic [31:0] d,
                        output logic [31:0] rd_o, output logic ok);
    reg_valid = 1'b1;
    reg_write = wr;
    reg_addr  = a;
    reg_wdata = d;
    ok   = 1'b0;
    rd_o = 32'd0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      if (reg_ready) begin
        ok   = 1'b1;
        rd_o = reg_rdata;
      end
    end
    @(posedge clk);
    #1;
    reg_valid = 1'b0;
    reg_write = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    logic        ok;
    access(1'b1, a, d, dummy, ok);
    chk("wr_ready", {31'd0, ok}, 32'd1);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string tag);
    logic [31:0] d;
    logic        ok;
    logic [31:0] ev;
    string       et;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    access(1'b0, a, 32'd0, d, ok);
    ev = exp_q.pop_front();
    et = tag_q.pop_front();
    chk({et, "_ready"}, {31'd0, ok}, 32'd1);
    if (ok) chk(et, d, ev);
  endtask

  task automatic reset_dut();
    resetn    = 1'b0;
    reg_valid = 1'b0;
    reg_write = 1'b0;
    reg_addr  = 3'd0;
    reg_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic check_reset_regs(input string pfx);
    logic [31:0] rexp [8];
    rexp = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), rexp[i], $sformatf("%s_reg%0d", pfx, i));
    end
  endtask

  initial begin
    int first_irq;
    int first_rst;
    int n_rst;
    int n_rst_b;

    reset_dut();

    // Reset state
    chk("rst_irq", {31'd0, wdog_irq}, 32'd0);
    chk("rst_rstreq", {31'd0, wdog_rst_req}, 32'd0);
    check_reset_regs("por");

    // PRESC=0: count k after edge k, IRQ one edge after count=5, RST one edge after count=10
    wr(ADDR_CMP_IRQ, 32'd5);
    wr(ADDR_CMP_RST, 32'd10);
    wr(ADDR_CTRL, 32'h0000_0001);
    mark();
    first_irq = -1;
    first_rst = -1;
    n_rst     = 0;
    for (int a = 1; a <= 30; a++) begin
      peek(a);
      if (wdog_irq && first_irq < 0) first_irq = a;
      if (wdog_rst_req && first_rst < 0) first_rst = a;
      if (wdog_rst_req) n_rst++;
      if (a == 27) chk("irq_after_rst", {31'd0, wdog_irq}, 32'd0);
    end
    chk("irq_rise_edge", 32'(first_irq), 32'd6);
    chk("rst_rise_edge", 32'(first_rst), 32'd11);
    chk("rst_pulse_len", 32'(n_rst), 32'd16);
    wait_to(31);
    rd(ADDR_CTRL, 32'd0, "ctrl_after_rst");
    rd(ADDR_COUNT, 32'd0, "count_after_rst");

    // PRESC=3: count k after edge 8k; wrong key ignored; right key clears
    wr(ADDR_CMP_IRQ, 32'd3);
    wr(ADDR_CMP_RST, 32'd20);
    wr(ADDR_CTRL, 32'h0000_0031);
    mark();
    rd(ADDR_COUNT, 32'd0, "p3_count_e1");
    wait_to(8);
    rd(ADDR_COUNT, 32'd1, "p3_count_e9");
    wait_to(10);
    wr(ADDR_FEED, 32'h0000_1234);
    wait_to(16);
    rd(ADDR_COUNT, 32'd2, "p3_count_badkey");
    peek(24);
    chk("p3_irq_e24", {31'd0, wdog_irq}, 32'd0);
    peek(25);
    chk("p3_irq_e25", {31'd0, wdog_irq}, 32'd1);
    wait_to(32);
    wr(ADDR_FEED, FEED_KEY_DEFAULT);
    peek(34);
    chk("feed_irq_drop", {31'd0, wdog_irq}, 32'd0);
    wait_to(35);
    rd(ADDR_COUNT, 32'd0, "feed_count_clr");
    rd(ADDR_CTRL, 32'h0000_0031, "p3_ctrl");

    // Configuration lock while running
    wr(ADDR_CTRL, 32'd0);
    wr(ADDR_CMP_IRQ, 32'd100);
    wr(ADDR_CMP_RST, 32'd200);
    wr(ADDR_CTRL, 32'h0000_0001);
    wr(ADDR_CMP_IRQ, 32'd7);
    rd(ADDR_CMP_IRQ, 32'd100, "cmp_locked");
    wr(ADDR_CTRL, 32'h0000_0051);
    rd(ADDR_CTRL, 32'h0000_0001, "presc_locked");
    wr(ADDR_CTRL, 32'd0);
    rd(ADDR_CTRL, 32'd0, "disabled_ctrl");
    rd(ADDR_COUNT, 32'd0, "disabled_count");
    wr(ADDR_CMP_IRQ, 32'd7);
    rd(ADDR_CMP_IRQ, 32'd7, "cmp_unlocked");

    // Feed committing on the edge the IRQ compare would act: count=7 after edge 7
    wr(ADDR_CTRL, 32'h0000_0001);
    mark();
    wait_to(6);
    wr(ADDR_FEED, FEED_KEY_DEFAULT);
    peek(8);
    chk("feed_race_irq_e8", {31'd0, wdog_irq}, 32'd0);
    peek(12);
    chk("feed_race_irq_e12", {31'd0, wdog_irq}, 32'd0);
    peek(16);
    chk("feed_race_irq_e16", {31'd0, wdog_irq}, 32'd1);
    wait_to(17);
    wr(ADDR_CTRL, 32'd0);

    // Disable committing on the edge the RST compare would act: count=6 after edge 6
    wr(ADDR_CMP_IRQ, 32'd3);
    wr(ADDR_CMP_RST, 32'd6);
    wr(ADDR_CTRL, 32'h0000_0001);
    mark();
    wait_to(5);
    wr(ADDR_CTRL, 32'd0);
    n_rst_b = 0;
    for (int a = 7; a <= 12; a++) begin
      peek(a);
      if (wdog_rst_req) n_rst_b++;
      if (a == 7) chk("dis_race_irq", {31'd0, wdog_irq}, 32'd0);
    end
    chk("dis_race_no_pulse", 32'(n_rst_b), 32'd0);
    wait_to(13);
    rd(ADDR_CTRL, 32'd0, "dis_race_ctrl");
    rd(ADDR_COUNT, 32'd0, "dis_race_count");

    // resetn low during the fifth cycle of the RST pulse (pulse starts after edge 7)
    wr(ADDR_CTRL, 32'h0000_0001);
    mark();
    peek(11);
    chk("pulse_c5_rstreq", {31'd0, wdog_rst_req}, 32'd1);
    resetn = 1'b0;
    peek(12);
    chk("abort_rstreq", {31'd0, wdog_rst_req}, 32'd0);
    chk("abort_irq", {31'd0, wdog_irq}, 32'd0);
    resetn = 1'b1;
    wait_to(13);
    check_reset_regs("abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
